sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameters SHALL be exactly:
- ADDR_W, default 10, word-address bits decoded.
- INIT_LEN, default sram_pkg::PROG_LEN, number of preloaded program words.
REQ-002 Ports SHALL be exactly:
- Clk  input  1  single clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low.
- A  input  20  word address from the processor.
- Mem_bus  inout  16  shared data bus.
- CE, OE, WE, UB, LB  input  1 each  active-low chip, output, write and byte-lane enables.
- Init_done  output  1  high once preload is complete.
REQ-003 Clk and Reset SHALL be the only clock and reset; Reset is asynchronous, active-low.

Function
REQ-004 Only A[ADDR_W-1:0] SHALL be decoded; A[19:ADDR_W] are ignored, so the array aliases every 2^ADDR_W words.
REQ-005 The FSM SHALL have exactly two states:
- INIT: after reset; a counter i steps 0 to 2^ADDR_W-1, one write per cycle.
- READY: entered the cycle after i = 2^ADDR_W-1 is written; held until Reset.
REQ-006 In INIT, word i SHALL be written with sram_pkg::PROG[i] when i < INIT_LEN, else 16'h0000.
REQ-007 Init_done SHALL be 0 in INIT and 1 in READY.
REQ-008 In INIT, processor strobes SHALL be ignored and Mem_bus SHALL be high-Z.
REQ-009 Write in READY: at a rising edge with CE=0 and WE=0, mem[A] SHALL be updated byte-wise:
- [15:8] from Mem_bus[15:8] when UB=0.
- [7:0] from Mem_bus[7:0] when LB=0.
- Lanes with UB=1 or LB=1 are left unchanged.
REQ-010 Read in READY: at a rising edge with CE=0, OE=0, WE=1, mem[A] SHALL be captured into a data register and a read-valid flag set, together with registered copies of UB and LB.
REQ-011 While read-valid=1, Mem_bus[15:8] SHALL be driven from the data register when the registered UB=0, else high-Z; [7:0] likewise with the registered LB.
REQ-012 Read latency SHALL be one cycle: the edge that samples the read gives bus data until the next rising edge.
REQ-013 Read-valid SHALL clear at any edge not meeting REQ-010, including CE=1, OE=1, or any write.
REQ-014 With WE=0 and OE=0 together, write SHALL take precedence; no read occurs and the bus is not driven.
REQ-015 Read-after-write to the same address on the next edge SHALL return the newly written data.
REQ-016 CE=1 SHALL inhibit both read and write regardless of the other strobes.
REQ-017 Mem_bus SHALL never be driven in the same cycle the strobes request a write.

Reset
REQ-018 Reset=0 SHALL asynchronously set:
- FSM = INIT, i = 0, Init_done = 0.
- read-valid = 0, Mem_bus high-Z.
REQ-019 Reset asserted mid-INIT or mid-access SHALL abort it and restart the full preload on release; array contents are not cleared by Reset itself.

Structure
REQ-020 Package sram_pkg SHALL hold:
- PROG_LEN and the PROG word table.
- The state enum {INIT, READY}.
- Bus width 16 and address width 20 constants.
REQ-021 The array SHALL be a sub-module sram_array: single port, synchronous read, two byte-write enables, depth 2^ADDR_W. The FSM, loader mux and tristate control stay in sram_responder.

Verification
REQ-022 Preload: PROG[0]=16'h5020, PROG[1]=16'h1021, release Reset -> Init_done rises exactly 1024 cycles later; read A=0 -> Mem_bus=16'h5020; A=1 -> 16'h1021; A=20'h003FF -> 16'h0000.
REQ-023 Byte write: write 16'hABCD at A=5 with UB=0, LB=1, then read A=5 -> 16'hAB00 (low byte keeps its preload 0); write 16'h1234 with LB=0, UB=1, read -> 16'hAB34.
REQ-024 Alias/contention: write 16'hBEEF at A=20'h00405, read A=20'h00005 -> 16'hBEEF; WE=0 and OE=0 with bus driven 16'h0F0F -> no contention, mem updated to 16'h0F0F.
REQ-025 Strobes: CE=1 with WE=0 -> memory unchanged and bus high-Z; read with UB=1, LB=0 -> Mem_bus[15:8]=Z and [7:0] = low data byte.
REQ-026 Reset mid-operation: Reset=0 at INIT count 300 -> Init_done=0 and bus high-Z immediately; after release, a full 1024-cycle preload runs and PROG contents reappear.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants, boot program table and FSM state type for the SRAM responder.
package sram_pkg;

    localparam int BUS_W       = 16;
    localparam int ADDR_FULL_W = 20;
    localparam int PROG_LEN    = 5;
    localparam int PROG_IDX_W  = $clog2(PROG_LEN);

    localparam logic [BUS_W-1:0] PROG [PROG_LEN] = '{
        16'h5020,
        16'h1021,
        16'h2822,
        16'h7C03,
        16'hE9F4
    };

    typedef enum logic {
        INIT,
        READY
    } state_t;

    // Words past the end of the program table load as zero.
    function automatic logic [BUS_W-1:0] prog_word(input logic [ADDR_FULL_W-1:0] idx);
        if (idx < ADDR_FULL_W'(PROG_LEN)) begin
            return PROG[idx[PROG_IDX_W-1:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port storage with synchronous read and independent upper/lower byte writes.
module sram_array
    import sram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we_hi,
    input  logic              we_lo,
    input  logic              re,
    input  logic [BUS_W-1:0]  wdata,
    output logic [BUS_W-1:0]  rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem_hi [DEPTH];
    logic [7:0] mem_lo [DEPTH];

    always_ff @(posedge clk) begin
        if (we_hi) begin
            mem_hi[addr] <= wdata[15:8];
        end
        if (we_lo) begin
            mem_lo[addr] <= wdata[7:0];
        end
        if (re) begin
            rdata <= {mem_hi[addr], mem_lo[addr]};
        end
    end

endmodule

// File: rtl/sram_responder.sv
// SRAM model for a processor bus: preloads the boot program after reset, then
// serves byte-lane reads and writes on a shared tristate data bus.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int INIT_LEN = PROG_LEN
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [ADDR_FULL_W-1:0] A,
    inout  wire  [BUS_W-1:0]       Mem_bus,
    input  logic                   CE,
    input  logic                   OE,
    input  logic                   WE,
    input  logic                   UB,
    input  logic                   LB,
    output logic                   Init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] init_cnt_q;

    logic              wr_req;
    logic              rd_req;
    logic              rd_vld_p1;
    logic              rd_ub_p1;
    logic              rd_lb_p1;

    logic [ADDR_W-1:0] arr_addr;
    logic              arr_we_hi;
    logic              arr_we_lo;
    logic              arr_re;
    logic [BUS_W-1:0]  arr_wdata;
    logic [BUS_W-1:0]  arr_rdata;

    logic              drive_hi;
    logic              drive_lo;
    logic              unused_addr_hi;

    function automatic logic [BUS_W-1:0] init_word(input logic [ADDR_W-1:0] idx);
        logic [ADDR_FULL_W-1:0] idx_ext;
        idx_ext = ADDR_FULL_W'(idx);
        if (idx_ext < ADDR_FULL_W'(INIT_LEN)) begin
            return prog_word(idx_ext);
        end
        return '0;
    endfunction

    // Upper address bits are deliberately ignored so the array aliases.
    assign unused_addr_hi = ^A[ADDR_FULL_W-1:ADDR_W];

    assign wr_req    = (state_q == READY) && !CE && !WE;
    assign rd_req    = (state_q == READY) && !CE && !OE && WE;
    assign Init_done = (state_q == READY);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            rd_vld_p1  <= 1'b0;
            rd_ub_p1   <= 1'b1;
            rd_lb_p1   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (state_q == INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            rd_vld_p1 <= rd_req;
            if (rd_req) begin
                rd_ub_p1 <= UB;
                rd_lb_p1 <= LB;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        arr_addr  = A[ADDR_W-1:0];
        arr_we_hi = 1'b0;
        arr_we_lo = 1'b0;
        arr_re    = 1'b0;
        arr_wdata = Mem_bus;
        case (state_q)
            INIT: begin
                arr_addr  = init_cnt_q;
                arr_we_hi = 1'b1;
                arr_we_lo = 1'b1;
                arr_wdata = init_word(init_cnt_q);
                if (init_cnt_q == LAST_ADDR) begin
                    state_d = READY;
                end
            end
            READY: begin
                arr_we_hi = wr_req && !UB;
                arr_we_lo = wr_req && !LB;
                arr_re    = rd_req;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    sram_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk  (Clk),
        .addr (arr_addr),
        .we_hi(arr_we_hi),
        .we_lo(arr_we_lo),
        .re   (arr_re),
        .wdata(arr_wdata),
        .rdata(arr_rdata)
    );

    // Read data holds for one cycle but yields the bus as soon as a write is requested.
    assign drive_hi = rd_vld_p1 && !rd_ub_p1 && !wr_req;
    assign drive_lo = rd_vld_p1 && !rd_lb_p1 && !wr_req;

    assign Mem_bus[15:8] = drive_hi ? arr_rdata[15:8] : 8'hzz;
    assign Mem_bus[7:0]  = drive_lo ? arr_rdata[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder with a word-array reference model.
module tb_sram_responder;
    import sram_pkg::*;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 1 << ADDR_W;
    localparam logic [15:0] FLOAT  = 16'hFFFF;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b0;
    logic [19:0] A     = '0;
    logic        CE    = 1'b1;
    logic        OE    = 1'b1;
    logic        WE    = 1'b1;
    logic        UB    = 1'b1;
    logic        LB    = 1'b1;
    logic        tb_drv  = 1'b0;
    logic [15:0] tb_data = '0;
    wire  [15:0] Mem_bus;
    logic        Init_done;

    int checks = 0;
    int errors = 0;

    logic [15:0] model [DEPTH];

    assign Mem_bus = tb_drv ? tb_data : 16'hzzzz;
    pullup (Mem_bus);

    sram_responder #(
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .A        (A),
        .Mem_bus  (Mem_bus),
        .CE       (CE),
        .OE       (OE),
        .WE       (WE),
        .UB       (UB),
        .LB       (LB),
        .Init_done(Init_done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] bus_view(input logic [15:0] w, input logic ub, input logic lb);
        return {ub ? 8'hFF : w[15:8], lb ? 8'hFF : w[7:0]};
    endfunction

    task automatic model_preload();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = (i < PROG_LEN) ? PROG[i] : 16'h0000;
        end
    endtask

    task automatic idle();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        tb_drv = 1'b0;
    endtask

    task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
        A = a; CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = ub; LB = lb;
        tb_data = d; tb_drv = 1'b1;
        @(posedge Clk); #1;
        if (!ub) model[a[ADDR_W-1:0]][15:8] = d[15:8];
        if (!lb) model[a[ADDR_W-1:0]][7:0]  = d[7:0];
        idle();
    endtask

    task automatic rd(input logic [19:0] a, input logic ub, input logic lb, output logic [15:0] got);
        A = a; CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = ub; LB = lb; tb_drv = 1'b0;
        @(posedge Clk); #1;
        got = Mem_bus;
        idle();
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (Init_done !== 1'b1 && n < 3000) begin
            @(posedge Clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        idle();
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Init_done !== 1'b0) begin
            errors++; $display("FAIL reset_init_done got %b expected 0", Init_done);
        end
        checks++;
        if (Mem_bus !== FLOAT) begin
            errors++; $display("FAIL reset_bus got %h expected %h", Mem_bus, FLOAT);
        end
    endtask

    task automatic test_preload();
        int n;
        logic [15:0] got;
        Reset = 1'b1;
        // Strobes during the preload must be ignored.
        A = 20'h00000; CE = 1'b0; WE = 1'b0; UB = 1'b0; LB = 1'b0; tb_data = 16'h9999; tb_drv = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        idle();
        wait_init(n);
        n += 10;
        model_preload();
        checks++;
        if (n != 1024) begin
            errors++; $display("FAIL preload_cycles got %0d expected 1024", n);
        end
        rd(20'h00000, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h5020) begin
            errors++; $display("FAIL preload_a0 got %h expected 5020", got);
        end
        rd(20'h00001, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h1021) begin
            errors++; $display("FAIL preload_a1 got %h expected 1021", got);
        end
        rd(20'h003FF, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h0000) begin
            errors++; $display("FAIL preload_a3ff got %h expected 0000", got);
        end
        for (int i = 2; i < PROG_LEN; i++) begin
            rd(20'(i), 1'b0, 1'b0, got);
            checks++;
            if (got !== model[i]) begin
                errors++; $display("FAIL preload_prog%0d got %h expected %h", i, got, model[i]);
            end
        end
    endtask

    task automatic test_byte_write();
        logic [15:0] got;
        wr(20'h00005, 16'hABCD, 1'b0, 1'b1);
        rd(20'h00005, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'hAB00) begin
            errors++; $display("FAIL byte_write_ub got %h expected AB00", got);
        end
        wr(20'h00005, 16'h1234, 1'b1, 1'b0);
        rd(20'h00005, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'hAB34) begin
            errors++; $display("FAIL byte_write_lb got %h expected AB34", got);
        end
    endtask

    task automatic test_alias_contention();
        logic [15:0] got;
        wr(20'h00405, 16'hBEEF, 1'b0, 1'b0);
        rd(20'h00005, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'hBEEF) begin
            errors++; $display("FAIL alias_read got %h expected BEEF", got);
        end
        // Read data is still on the bus; a write with OE also low must take over cleanly.
        A = 20'h00005; CE = 1'b0; WE = 1'b0; OE = 1'b0; UB = 1'b0; LB = 1'b0;
        tb_data = 16'h0F0F; tb_drv = 1'b1;
        #1;
        checks++;
        if (Mem_bus !== 16'h0F0F) begin
            errors++; $display("FAIL contention_bus got %h expected 0F0F", Mem_bus);
        end
        @(posedge Clk); #1;
        model[5] = 16'h0F0F;
        idle();
        #1;
        checks++;
        if (Mem_bus !== FLOAT) begin
            errors++; $display("FAIL we_oe_no_read got %h expected %h", Mem_bus, FLOAT);
        end
        rd(20'h00005, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h0F0F) begin
            errors++; $display("FAIL we_oe_write got %h expected 0F0F", got);
        end
    endtask

    task automatic test_strobes();
        logic [15:0] got;
        @(posedge Clk); #1;
        A = 20'h00005; CE = 1'b1; WE = 1'b0; OE = 1'b1; UB = 1'b0; LB = 1'b0;
        tb_data = 16'h5555; tb_drv = 1'b1;
        @(posedge Clk); #1;
        tb_drv = 1'b0;
        #1;
        checks++;
        if (Mem_bus !== FLOAT) begin
            errors++; $display("FAIL ce_high_bus got %h expected %h", Mem_bus, FLOAT);
        end
        A = 20'h00005; CE = 1'b1; WE = 1'b1; OE = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (Mem_bus !== FLOAT) begin
            errors++; $display("FAIL ce_high_read got %h expected %h", Mem_bus, FLOAT);
        end
        idle();
        rd(20'h00005, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h0F0F) begin
            errors++; $display("FAIL ce_high_nowrite got %h expected 0F0F", got);
        end
        rd(20'h00005, 1'b1, 1'b0, got);
        checks++;
        if (got !== 16'hFF0F) begin
            errors++; $display("FAIL lane_lb_only got %h expected FF0F", got);
        end
        rd(20'h00001, 1'b0, 1'b1, got);
        checks++;
        if (got !== 16'h10FF) begin
            errors++; $display("FAIL lane_ub_only got %h expected 10FF", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] a;
        logic [15:0] d;
        for (int k = 0; k < 8; k++) begin
            a = 20'($urandom);
            d = 16'($urandom);
            A = a; CE = 1'b0; WE = 1'b0; OE = 1'b1; UB = 1'b0; LB = 1'b0;
            tb_data = d; tb_drv = 1'b1;
            @(posedge Clk); #1;
            model[a[ADDR_W-1:0]] = d;
            tb_drv = 1'b0; WE = 1'b1; OE = 1'b0;
            @(posedge Clk); #1;
            checks++;
            if (Mem_bus !== d) begin
                errors++; $display("FAIL raw_next_edge a=%h got %h expected %h", a, Mem_bus, d);
            end
        end
        idle();
    endtask

    task automatic test_random();
        logic [19:0] a;
        logic [15:0] d;
        logic [15:0] exp_bus;
        logic        ce, oe, we, ub, lb, is_wr, is_rd;
        for (int k = 0; k < 400; k++) begin
            a  = 20'($urandom);
            if (k % 2 == 0) a[19:4] = '0;
            d  = 16'($urandom);
            ce = ($urandom_range(0, 7) == 0);
            oe = 1'($urandom);
            we = 1'($urandom);
            ub = ($urandom_range(0, 3) == 0);
            lb = ($urandom_range(0, 3) == 0);
            is_wr = !ce && !we;
            is_rd = !ce && !oe && we;
            A = a; CE = ce; OE = oe; WE = we; UB = ub; LB = lb;
            tb_data = d; tb_drv = is_wr;
            exp_bus = is_rd ? bus_view(model[a[ADDR_W-1:0]], ub, lb) : FLOAT;
            @(posedge Clk); #1;
            if (is_wr) begin
                if (!ub) model[a[ADDR_W-1:0]][15:8] = d[15:8];
                if (!lb) model[a[ADDR_W-1:0]][7:0]  = d[7:0];
            end else begin
                checks++;
                if (Mem_bus !== exp_bus) begin
                    errors++;
                    $display("FAIL random op%0d a=%h ce%b oe%b we%b ub%b lb%b got %h expected %h",
                             k, a, ce, oe, we, ub, lb, Mem_bus, exp_bus);
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        int n;
        wr(20'h00000, 16'h1111, 1'b0, 1'b0);
        wr(20'h00200, 16'h2222, 1'b0, 1'b0);
        rd(20'h00000, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h1111) begin
            errors++; $display("FAIL overwrite_a0 got %h expected 1111", got);
        end
        // Bus is still carrying read data here; reset must release it at once.
        Reset = 1'b0;
        #1;
        checks++;
        if (Mem_bus !== FLOAT || Init_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_access bus %h done %b expected %h 0", Mem_bus, Init_done, FLOAT);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        repeat (300) @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if (Mem_bus !== FLOAT || Init_done !== 1'b0) begin
            errors++; $display("FAIL reset_mid_init bus %h done %b expected %h 0", Mem_bus, Init_done, FLOAT);
        end
        @(posedge Clk); #1;
        Reset = 1'b1;
        wait_init(n);
        model_preload();
        checks++;
        if (n != 1024) begin
            errors++; $display("FAIL repreload_cycles got %0d expected 1024", n);
        end
        rd(20'h00000, 1'b0, 1'b0, got);
        checks++;
        if (got !== model[0]) begin
            errors++; $display("FAIL repreload_a0 got %h expected %h", got, model[0]);
        end
        rd(20'h00001, 1'b0, 1'b0, got);
        checks++;
        if (got !== model[1]) begin
            errors++; $display("FAIL repreload_a1 got %h expected %h", got, model[1]);
        end
        rd(20'h00200, 1'b0, 1'b0, got);
        checks++;
        if (got !== 16'h0000) begin
            errors++; $display("FAIL repreload_a200 got %h expected 0000", got);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_byte_write();
        test_alias_contention();
        test_strobes();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
